// File: rtl/frame_capture_ddr.sv
// Captures active video lines into a ping-pong line buffer and drains each full line to DDR one 32-bit word at a time.
// Define FRAME_CAPTURE_BGR_EN to pack pixels as {8'h00,b,g,r} instead of {8'h00,r,g,b}.
//
// state | meaning
// IDLE  | no line being drained; waits for a full bank
// FETCH | read of the current word issued to the line RAM
// REQ   | one-cycle DDR write request with address and data
// WAIT  | request outstanding until ddr_ready
module frame_capture_ddr #(
  parameter int LINE_PIXELS = 512,
  parameter int LINE_STRIDE = 2048
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ce_pix,
  input  logic        hblank,
  input  logic        vblank,
  input  logic        vs,
  input  logic [7:0]  r,
  input  logic [7:0]  g,
  input  logic [7:0]  b,
  input  logic        enable,
  input  logic [27:0] frame_base,
  output logic [27:0] ddr_addr,
  output logic [31:0] ddr_din,
  output logic        ddr_req,
  output logic        ddr_rnw,
  input  logic        ddr_ready,
  output logic        busy,
  output logic        overflow,
  output logic        frame_done,
  output logic [9:0]  lines_written
);

  localparam int PW = $clog2(LINE_PIXELS);

  typedef enum logic [1:0] {IDLE, FETCH, REQ, WAIT} state_t;

  state_t        state, state_nxt;
  logic          vs_d, hb_d, capturing;
  logic [27:0]   base_q;
  logic [9:0]    line_idx;
  logic [PW:0]   wr_ptr;
  logic          wr_bank;
  logic [1:0]    full;
  logic          oldest;
  logic [PW:0]   cnt   [2];
  logic [27:0]   laddr [2];
  logic          dr_bank;
  logic [PW-1:0] word;
  logic [31:0]   mem [2][LINE_PIXELS];
  logic [31:0]   rd_q;

  logic          vs_rise, hb_rise, pix_we, line_end, last_word, drain_done;
  logic          other_empty, accept, drop, pick;
  logic [31:0]   pix_word;
  logic [27:0]   line_addr;

`ifdef FRAME_CAPTURE_BGR_EN
  assign pix_word = {8'h00, b, g, r};
`else
  assign pix_word = {8'h00, r, g, b};
`endif

  assign vs_rise    = vs & ~vs_d;
  assign hb_rise    = hblank & ~hb_d;
  assign pix_we     = capturing & ce_pix & ~hblank & ~vblank & ~vs_rise
                      & (wr_ptr < (PW+1)'(LINE_PIXELS));
  assign line_end   = hb_rise & (wr_ptr != '0) & ~vs_rise;
  assign last_word  = ({1'b0, word} == cnt[dr_bank] - 1'b1);
  assign drain_done = (state == WAIT) & ddr_ready & last_word;
  // A bank freed by the drain on this very cycle already counts as empty for the fill side.
  assign other_empty = ~full[~wr_bank] | (drain_done & (dr_bank == ~wr_bank));
  // After a new frame resets the write bank to 0, that bank may still hold an undrained line.
  assign accept     = line_end & other_empty & ~full[wr_bank];
  assign drop       = line_end & ~accept;
  assign line_addr  = base_q + 28'(line_idx) * 28'(LINE_STRIDE);
  assign pick       = (full[0] & full[1]) ? oldest : ~full[0];
  assign ddr_din    = rd_q;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      vs_d       <= 1'b0;
      hb_d       <= 1'b0;
      capturing  <= 1'b0;
      base_q     <= '0;
      line_idx   <= '0;
      wr_ptr     <= '0;
      wr_bank    <= 1'b0;
      overflow   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      vs_d       <= vs;
      hb_d       <= hblank;
      frame_done <= vs_rise & capturing;
      if (vs_rise) begin
        capturing <= enable;
        base_q    <= frame_base;
        line_idx  <= '0;
        wr_ptr    <= '0;
        wr_bank   <= 1'b0;
      end else if (line_end) begin
        wr_ptr   <= '0;
        line_idx <= line_idx + 1'b1;
        if (accept) wr_bank <= ~wr_bank;
        if (drop) overflow <= 1'b1;
      end else if (pix_we) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      full     <= '0;
      oldest   <= 1'b0;
      cnt[0]   <= '0;
      cnt[1]   <= '0;
      laddr[0] <= '0;
      laddr[1] <= '0;
    end else begin
      if (accept) begin
        full[wr_bank]  <= 1'b1;
        cnt[wr_bank]   <= wr_ptr;
        laddr[wr_bank] <= line_addr;
        oldest         <= full[~wr_bank] & ~drain_done ? ~wr_bank : wr_bank;
      end
      if (drain_done) full[dr_bank] <= 1'b0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (pix_we & ~full[wr_bank]) mem[wr_bank][wr_ptr[PW-1:0]] <= pix_word;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) rd_q <= '0;
    else if (state == FETCH) rd_q <= mem[dr_bank][word];
  end

  always_ff @(posedge clk_sys) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|full) state_nxt = FETCH;
      FETCH:   state_nxt = REQ;
      REQ:     state_nxt = WAIT;
      WAIT:    if (ddr_ready) state_nxt = last_word ? IDLE : FETCH;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ddr_req = (state == REQ);
    ddr_rnw = 1'b0;
    busy    = (state != IDLE) | (|full);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      dr_bank       <= 1'b0;
      word          <= '0;
      ddr_addr      <= '0;
      lines_written <= '0;
    end else begin
      case (state)
        IDLE:  if (|full) begin
                 dr_bank <= pick;
                 word    <= '0;
               end
        FETCH: ddr_addr <= laddr[dr_bank] + 28'({word, 2'b00});
        WAIT:  if (ddr_ready & ~last_word) word <= word + 1'b1;
        default: ;
      endcase
      if (vs_rise)         lines_written <= '0;
      else if (drain_done) lines_written <= lines_written + 1'b1;
    end
  end

endmodule

// File: tb/tb_frame_capture_ddr.sv
// Directed bench for frame_capture_ddr: DDR responder with hold-off, request monitor and hand-computed expectations.
module tb_frame_capture_ddr;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ce_pix = 1'b0, hblank = 1'b1, vblank = 1'b0, vs = 1'b0;
  logic [7:0]  r = '0, g = '0, b = '0;
  logic        enable = 1'b0;
  logic [27:0] frame_base = '0;
  logic [27:0] ddr_addr;
  logic [31:0] ddr_din;
  logic        ddr_req, ddr_rnw;
  logic        ddr_ready = 1'b0;
  logic        busy, overflow, frame_done;
  logic [9:0]  lines_written;

  frame_capture_ddr dut (
    .clk_sys(clk_sys), .reset(reset), .ce_pix(ce_pix), .hblank(hblank), .vblank(vblank), .vs(vs),
    .r(r), .g(g), .b(b), .enable(enable), .frame_base(frame_base),
    .ddr_addr(ddr_addr), .ddr_din(ddr_din), .ddr_req(ddr_req), .ddr_rnw(ddr_rnw), .ddr_ready(ddr_ready),
    .busy(busy), .overflow(overflow), .frame_done(frame_done), .lines_written(lines_written)
  );

  always #5 clk_sys = ~clk_sys;

  int checks = 0, failures = 0;
  int fd_cnt = 0, stab_err = 0;
  logic [27:0] addr_q[$];
  logic [31:0] din_q[$];
  logic [7:0]  pr_off = 8'h00, pg = 8'h5a, pb = 8'hc3;
  bit          hold_off = 1'b0, manual_ready = 1'b0, pend = 1'b0, out_pend = 1'b0;
  int          dly = 0;
  logic [27:0] hold_a;
  logic [31:0] hold_d;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input logic [7:0] rr, input logic [7:0] gg, input logic [7:0] bb);
`ifdef FRAME_CAPTURE_BGR_EN
    return {8'h00, bb, gg, rr};
`else
    return {8'h00, rr, gg, bb};
`endif
  endfunction

  function automatic logic [31:0] q_at(input int k);
    return (addr_q.size() > k) ? 32'(addr_q[k]) : 32'hffff_ffff;
  endfunction

  // DDR responder: completes each request a few cycles later unless held off.
  always @(posedge clk_sys) begin
    ddr_ready <= manual_ready;
    if (reset) pend <= 1'b0;
    else if (ddr_req) begin
      pend <= 1'b1;
      dly  <= 2;
    end else if (pend && !hold_off) begin
      if (dly == 0) begin
        ddr_ready <= 1'b1;
        pend      <= 1'b0;
      end else dly <= dly - 1;
    end
  end

  always @(negedge clk_sys) begin
    if (frame_done) fd_cnt++;
    if (ddr_req) begin
      addr_q.push_back(ddr_addr);
      din_q.push_back(ddr_din);
      out_pend = 1'b1;
      hold_a   = ddr_addr;
      hold_d   = ddr_din;
    end else if (out_pend) begin
      if (!busy) out_pend = 1'b0;
      else begin
        if (ddr_addr !== hold_a || ddr_din !== hold_d) stab_err++;
        if (ddr_ready) out_pend = 1'b0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic vs_pulse(input logic en, input logic [27:0] base);
    @(negedge clk_sys);
    enable = en; frame_base = base; vs = 1'b1;
    @(negedge clk_sys);
    vs = 1'b0;
    tick(4);
  endtask

  task automatic send_line(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_sys);
      hblank = 1'b0; ce_pix = 1'b1;
      r = pr_off + 8'(i); g = pg; b = pb;
    end
    @(negedge clk_sys);
    hblank = 1'b1; ce_pix = 1'b0;
    tick(gap);
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int n = 0;
    while (busy && n < limit) begin
      @(negedge clk_sys);
      n++;
    end
    check(tag, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    int errs, derr, in_gap, fd0, fd1, n;

    tick(3);
    check("rst_req", {31'b0, ddr_req}, 0);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_overflow", {31'b0, overflow}, 0);
    check("rst_frame_done", {31'b0, frame_done}, 0);
    check("rst_lines", 32'(lines_written), 0);
    check("rst_addr", 32'(ddr_addr), 0);
    check("rst_din", ddr_din, 0);
    check("rst_rnw", {31'b0, ddr_rnw}, 0);
    reset = 1'b0;
    tick(2);

    // Full-width line, r = pixel index
    vs_pulse(1'b1, 28'h0100000);
    addr_q.delete(); din_q.delete();
    send_line(512, 4);
    wait_idle("a_drain", 20000);
    check("a_req_count", addr_q.size(), 512);
    errs = 0; derr = 0;
    for (int k = 0; k < addr_q.size(); k++) begin
      if (addr_q[k] !== 28'h0100000 + 28'(4 * k)) errs++;
      if (din_q[k] !== exp_word(8'(k), pg, pb)) derr++;
    end
    check("a_addr_seq", errs, 0);
    check("a_din_seq", derr, 0);
    check("a_first_addr", q_at(0), 32'h0100000);
    check("a_last_addr", q_at(511), 32'h01007fc);
    check("a_lines", 32'(lines_written), 1);

    // Short line, then the next line lands one stride later
    vs_pulse(1'b1, 28'h0100000);
    check("b_lines_cleared", 32'(lines_written), 0);
    check("b_frame_done", fd_cnt, 1);
    addr_q.delete(); din_q.delete();
    send_line(100, 20);
    wait_idle("b_drain1", 5000);
    check("b_req_count1", addr_q.size(), 100);
    check("b_last_addr", q_at(99), 32'h010018c);
    send_line(10, 20);
    wait_idle("b_drain2", 5000);
    check("b_line2_addr", q_at(100), 32'h0100800);
    check("b_req_count2", addr_q.size(), 110);
    check("b_lines", 32'(lines_written), 2);

    // Held-off DDR: third line dropped, fourth line at base + 3*stride
    vs_pulse(1'b1, 28'h0200000);
    addr_q.delete(); din_q.delete();
    send_line(8, 20);
    wait_idle("c_drain1", 2000);
    hold_off = 1'b1;
    send_line(8, 20);
    send_line(8, 3000);
    check("c_overflow", {31'b0, overflow}, 1);
    check("c_busy_held", {31'b0, busy}, 1);
    hold_off = 1'b0;
    wait_idle("c_drain2", 2000);
    send_line(8, 20);
    wait_idle("c_drain4", 2000);
    check("c_req_count", addr_q.size(), 24);
    check("c_line1_addr", q_at(8), 32'h0200800);
    check("c_line3_addr", q_at(16), 32'h0201800);
    in_gap = 0;
    foreach (addr_q[k]) if (addr_q[k] >= 28'h0201000 && addr_q[k] < 28'h0201800) in_gap++;
    check("c_dropped_line", in_gap, 0);
    check("c_lines", 32'(lines_written), 3);

    // Disarmed frame
    fd0 = fd_cnt;
    vs_pulse(1'b0, 28'h0300000);
    check("d_prev_frame_done", fd_cnt, fd0 + 1);
    addr_q.delete(); din_q.delete();
    send_line(16, 40);
    check("d_no_req", addr_q.size(), 0);
    check("d_not_busy", {31'b0, busy}, 0);
    fd1 = fd_cnt;
    vs_pulse(1'b1, 28'h0400000);
    check("d_no_frame_done", fd_cnt, fd1);

    // Pixel packing
    addr_q.delete(); din_q.delete();
    pr_off = 8'h11; pg = 8'h22; pb = 8'h33;
    send_line(1, 20);
    wait_idle("f_drain", 500);
    check("f_addr", q_at(0), 32'h0400000);
`ifdef FRAME_CAPTURE_BGR_EN
    check("f_pack", (din_q.size() > 0) ? din_q[0] : 32'hffff_ffff, 32'h00332211);
`else
    check("f_pack", (din_q.size() > 0) ? din_q[0] : 32'hffff_ffff, 32'h00112233);
`endif
    pr_off = 8'h00; pg = 8'h5a; pb = 8'hc3;

    // Reset one cycle after the request, then a stray ddr_ready
    hold_off = 1'b1;
    addr_q.delete(); din_q.delete();
    send_line(4, 0);
    n = 0;
    while (!ddr_req && n < 50) begin
      @(negedge clk_sys);
      n++;
    end
    check("e_req_seen", {31'b0, ddr_req}, 1);
    @(negedge clk_sys);
    reset = 1'b1;
    @(negedge clk_sys);
    reset = 1'b0;
    check("e_req", {31'b0, ddr_req}, 0);
    check("e_busy", {31'b0, busy}, 0);
    check("e_overflow", {31'b0, overflow}, 0);
    check("e_addr", 32'(ddr_addr), 0);
    check("e_din", ddr_din, 0);
    manual_ready = 1'b1;
    @(negedge clk_sys);
    manual_ready = 1'b0;
    tick(6);
    check("e_late_busy", {31'b0, busy}, 0);
    check("e_late_lines", 32'(lines_written), 0);
    check("e_late_req_count", addr_q.size(), 1);
    hold_off = 1'b0;

    check("hold_stable", stab_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
